// File: rtl/binary_to_bcd_sequencer_if.sv
// Handshake and result bundle between the binary event counter, the double-dabble
// converter and the seven-segment digit driver.
interface binary_to_bcd_sequencer_if #(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 4
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   bin_in;
  logic                   busy;
  logic                   done;
  logic [4*DIGITS-1:0]    bcd_out;
  logic [DIGITS-1:0]      digit_mask;
  logic                   overflow;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, digit_mask, overflow
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, digit_mask, overflow
  );
endinterface

// File: rtl/binary_to_bcd_sequencer.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock, with
// saturation on overflow and a leading-zero blanking mask held between conversions.
module binary_to_bcd_sequencer #(
  parameter int unsigned BIN_WIDTH = 10,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  binary_to_bcd_sequencer_if.slave    bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q,    state_d;
  logic [BIN_WIDTH-1:0] shift_q,    shift_d;
  logic [BCD_W-1:0]     scratch_q,  scratch_d;
  logic                 ovf_q,      ovf_d;
  logic [CNT_W-1:0]     cnt_q,      cnt_d;
  logic [BCD_W-1:0]     bcd_q,      bcd_d;
  logic [DIGITS-1:0]    mask_q,     mask_d;
  logic                 overflow_q, overflow_d;

  logic [BCD_W-1:0]     corr;
  logic [BCD_W-1:0]     scratch_next;
  logic                 ovf_next;
  logic [DIGITS-1:0]    mask_next;
  logic                 any_nz;

  // One double-dabble step: add-3 on every digit >= 5, then shift one binary bit in.
  always_comb begin
    corr = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        corr[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    scratch_next = {corr[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
    ovf_next     = ovf_q | corr[BCD_W-1];
  end

  // Digit k is significant when it or any more-significant digit is nonzero.
  always_comb begin
    any_nz    = 1'b0;
    mask_next = '0;
    for (int k = int'(DIGITS) - 1; k > 0; k--) begin
      any_nz       = any_nz | (scratch_next[4*k +: 4] != 4'd0);
      mask_next[k] = any_nz;
    end
    mask_next[0] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    mask_d     = mask_q;
    overflow_d = overflow_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          state_d   = S_SHIFT;
          shift_d   = bus.bin_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
        end
      end
      S_SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = scratch_next;
        ovf_d     = ovf_next;
        cnt_d     = cnt_q + CNT_W'(1);
        // Result is published only on the edge that enters DONE.
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d    = S_DONE;
          overflow_d = ovf_next;
          bcd_d      = ovf_next ? {DIGITS{4'h9}} : scratch_next;
          mask_d     = ovf_next ? {DIGITS{1'b1}} : mask_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      mask_q     <= DIGITS'(1);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy       = (state_q == S_SHIFT);
  assign bus.done       = (state_q == S_DONE);
  assign bus.bcd_out    = bcd_q;
  assign bus.digit_mask = mask_q;
  assign bus.overflow   = overflow_q;

endmodule
